shared_slow_memory: RTL and testbench
=====================================

# shared_slow_memory

Parametrised multi-channel slow memory for the CHIP simulation environment. It replaces the separate per-port slow memories with one line-wide memory array. N_CH request channels (for example I-cache and D-cache) share the array through round-robin arbitration, and each access completes after a programmable latency. It also provides a busy flag, a grant indicator, a transfer counter and a sticky protocol-error flag so benches can measure memory traffic.

## Interface
- N_CH, 2: number of request channels, ≥1.
- ADDR_W, 28: line-address width per channel (byte address bits [31:4]).
- LINE_W, 128: line width in bits.
- IDX_W, 10: index bits; DEPTH = 2**IDX_W lines.
- LATENCY, 4: cycles from request sample to ready; must be ≥2.
- CH_W, derived: max(1, clog2(N_CH)).
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_read  in  N_CH  per-channel read request; level, held until ready.
- mem_write  in  N_CH  per-channel write request; level, held until ready.
- mem_addr  in  N_CH*ADDR_W  line address; channel c occupies bits [c*ADDR_W +: ADDR_W].
- mem_wdata  in  N_CH*LINE_W  write line, packed the same way.
- mem_rdata  out  N_CH*LINE_W  per-channel read line register.
- mem_ready  out  N_CH  one-cycle completion pulse per channel.
- busy  out  1  high whenever the state is not IDLE.
- grant_ch  out  CH_W  channel currently being served; holds the last value when idle.
- xfer_cnt  out  16  completed transactions; saturates at 16'hFFFF.
- proto_err  out  1  sticky; set when a sampled channel has read and write high together.

## Operation
- Storage: array named mem[0:DEPTH-1] of LINE_W bits, preloadable by the bench. Reset does not clear it.
- Only addr[IDX_W-1:0] is used as the index; upper address bits alias.
- States and transitions:
  - IDLE: a channel is requesting when mem_read[c] or mem_write[c] is high.
    - If any channel requests, grant the first requesting channel at or after rr_ptr, searching upward with wrap.
    - Latch the granted channel, op, index and wdata. Load cnt = LATENCY-1, then go to BUSY.
    - rr_ptr becomes (grant+1) mod N_CH.
  - BUSY: decrement cnt each cycle. When cnt reaches 1, perform the access and go to RESP.
    - Write: mem[idx] is updated with the latched wdata.
    - Read: mem_rdata of the granted channel is loaded from mem[idx].
  - RESP: mem_ready[grant] = 1 for exactly this cycle, xfer_cnt increments (saturating), then return to IDLE.
- A request with read and write both high is performed as a write, and proto_err is set.
- Latched values are used for the whole transaction:
  - Changes to addr or wdata, or a dropped request, after the sample edge do not affect the transaction.
  - Ready still pulses for the granted channel.
- mem_rdata for a channel changes only on that channel's read completion. Other channels' values hold.
- Write completions leave every mem_rdata unchanged.
- A channel that keeps its request high after its ready pulse is treated as a new request in the next IDLE cycle.

## Timing
- A request sampled at edge T (state IDLE) produces:
  - the memory update or rdata load at edge T+LATENCY-1;
  - mem_ready high from edge T+LATENCY-1 to T+LATENCY;
  - state in IDLE at T+LATENCY. The next grant is sampled no earlier than edge T+LATENCY.
- Throughput is one transaction per LATENCY+1 cycles. No pipelining.
- Reset values: mem_ready=0, mem_rdata=0, busy=0, grant_ch=0, xfer_cnt=0, proto_err=0, rr_ptr=0, state IDLE.
- Reset asserted mid-transaction aborts it:
  - there is no memory write and no ready pulse;
  - outputs take their reset values immediately, asynchronously.
- Simultaneous requests: exactly one is granted. A losing channel is served within N_CH-1 further transactions (fairness bound).

## Test plan
- Single read, LATENCY=4:
  - Stimulus: preload mem[5]=128'hA5..A5; raise mem_read[0] with addr 5 before edge 10.
  - Response: mem_ready[0] high only in cycle 13–14; rdata ch0 = A5..A5; xfer_cnt=1.
- Write then read:
  - Stimulus: ch1 writes 128'h1234 to addr 28'h400 (alias of idx 0 at IDX_W=10); ch1 then reads addr 0.
  - Response: returns 128'h1234; ch0 rdata remains 0.
- Contention, N_CH=2, both channels held high:
  - Grants alternate 0,1,0,1 and grant_ch follows.
  - Ready pulses are 5 cycles apart.
  - xfer_cnt=4 after 20 cycles.
- Protocol error:
  - Stimulus: ch0 raises read and write together with wdata=128'hFF, addr 3.
  - Response: mem[3]=FF; proto_err=1 and stays 1 until reset.
- Reset mid-operation:
  - Stimulus: assert rst two cycles after a write grant to addr 7.
  - Response: mem[7] unchanged; no mem_ready; busy=0 immediately after rst rises.
- Saturation:
  - Stimulus: force xfer_cnt to 16'hFFFE, then complete 3 transactions.
  - Response: xfer_cnt reads 16'hFFFF.

Source files
------------

// File: rtl/shared_slow_memory_if.sv
// Request/response bundle between the request channels and the shared slow memory.
interface shared_slow_memory_if #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
);
    logic [N_CH-1:0]        mem_read;
    logic [N_CH-1:0]        mem_write;
    logic [N_CH*ADDR_W-1:0] mem_addr;
    logic [N_CH*LINE_W-1:0] mem_wdata;
    logic [N_CH*LINE_W-1:0] mem_rdata;
    logic [N_CH-1:0]        mem_ready;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/shared_slow_memory.sv
// Line-wide slow memory shared by N_CH request channels. Requests are
// arbitrated round-robin, one transaction at a time, each completing after
// LATENCY cycles with a one-cycle ready pulse on the served channel.
module shared_slow_memory #(
    parameter int N_CH    = 2,
    parameter int ADDR_W  = 28,
    parameter int LINE_W  = 128,
    parameter int IDX_W   = 10,
    parameter int LATENCY = 4,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    shared_slow_memory_if.slave bus,
    output logic                busy,
    output logic [CH_W-1:0]     grant_ch,
    output logic [15:0]         xfer_cnt,
    output logic                proto_err
);
    localparam int DEPTH = 2 ** IDX_W;
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                 state;
    logic [LINE_W-1:0]      mem [0:DEPTH-1];
    logic [CH_W-1:0]        rr_ptr;
    logic [CNT_W-1:0]       cnt;
    logic                   op_wr;
    logic [IDX_W-1:0]       idx_q;
    logic [LINE_W-1:0]      wdata_q;
    logic [N_CH*LINE_W-1:0] rdata_q;
    logic [N_CH-1:0]        ready_q;

    logic [N_CH-1:0]        req;
    logic                   found;
    logic [CH_W-1:0]        pick;
    logic                   pick_rd;
    logic                   pick_wr;
    logic [IDX_W-1:0]       pick_idx;
    logic [LINE_W-1:0]      pick_wdata;

    // Channel number modulo N_CH, used for the wrap-around search and rr_ptr update.
    function automatic logic [CH_W-1:0] wrap_ch(input int v);
        return CH_W'(v % N_CH);
    endfunction

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_ready = ready_q;

    assign pick_rd    = bus.mem_read[pick];
    assign pick_wr    = bus.mem_write[pick];
    assign pick_idx   = bus.mem_addr[int'(pick)*ADDR_W +: IDX_W];
    assign pick_wdata = bus.mem_wdata[int'(pick)*LINE_W +: LINE_W];

    // Round-robin pick: first requesting channel at or after rr_ptr, wrapping upward.
    always_comb begin
        req   = bus.mem_read | bus.mem_write;
        found = 1'b0;
        pick  = rr_ptr;
        for (int i = 0; i < N_CH; i++) begin
            if (!found && req[wrap_ch(int'(rr_ptr) + i)]) begin
                found = 1'b1;
                pick  = wrap_ch(int'(rr_ptr) + i);
            end
        end
    end

    // Transaction FSM: latch a request in IDLE, count down in BUSY, pulse ready in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            grant_ch  <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            op_wr     <= 1'b0;
            xfer_cnt  <= '0;
            proto_err <= 1'b0;
            rdata_q   <= '0;
            ready_q   <= '0;
        end else begin
            ready_q <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_ch <= pick;
                        op_wr    <= pick_wr;
                        idx_q    <= pick_idx;
                        wdata_q  <= pick_wdata;
                        cnt      <= CNT_W'(LATENCY - 1);
                        rr_ptr   <= wrap_ch(int'(pick) + 1);
                        state    <= BUSY;
                        busy     <= 1'b1;
                        if (pick_rd && pick_wr) begin
                            proto_err <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        if (!op_wr) begin
                            rdata_q[int'(grant_ch)*LINE_W +: LINE_W] <= mem[idx_q];
                        end
                        ready_q[grant_ch] <= 1'b1;
                        state             <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (xfer_cnt != 16'hFFFF) begin
                        xfer_cnt <= xfer_cnt + 16'd1;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage write on the final BUSY cycle; contents survive reset.
    always_ff @(posedge clk) begin
        if (state == BUSY && cnt == CNT_W'(1) && op_wr) begin
            mem[idx_q] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_shared_slow_memory.sv
// Randomized and directed bench for shared_slow_memory against a
// transaction-level reference model.
module tb_shared_slow_memory;
    localparam int N_CH    = 2;
    localparam int ADDR_W  = 28;
    localparam int LINE_W  = 128;
    localparam int IDX_W   = 10;
    localparam int LATENCY = 4;
    localparam int CH_W    = 1;
    localparam int DEPTH   = 2 ** IDX_W;

    logic            clk = 1'b0;
    logic            rst;
    logic            busy;
    logic [CH_W-1:0] grant_ch;
    logic [15:0]     xfer_cnt;
    logic            proto_err;

    shared_slow_memory_if #(.N_CH(N_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus();

    shared_slow_memory #(
        .N_CH(N_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .IDX_W(IDX_W), .LATENCY(LATENCY)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .busy(busy), .grant_ch(grant_ch), .xfer_cnt(xfer_cnt), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [LINE_W-1:0] mem_m [DEPTH];
    logic [LINE_W-1:0] rd_m  [N_CH];
    int                rr_m;
    logic [15:0]       xfer_m;
    logic              proto_m;

    // Per-channel transaction (op: 0 read, 1 write, 2 read+write)
    int                op_t   [N_CH];
    logic [ADDR_W-1:0] addr_t [N_CH];
    logic [LINE_W-1:0] data_t [N_CH];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [N_CH*LINE_W-1:0] rd_vec();
        logic [N_CH*LINE_W-1:0] v;
        for (int c = 0; c < N_CH; c++) v[c*LINE_W +: LINE_W] = rd_m[c];
        return v;
    endfunction

    task automatic drive_ch(input int c);
        bus.mem_read[c]                   = (op_t[c] != 1);
        bus.mem_write[c]                  = (op_t[c] != 0);
        bus.mem_addr[c*ADDR_W +: ADDR_W]  = addr_t[c];
        bus.mem_wdata[c*LINE_W +: LINE_W] = data_t[c];
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) rd_m[c] = '0;
        rr_m    = 0;
        xfer_m  = '0;
        proto_m = 1'b0;
    endtask

    // Present the channels in mask (DUT idle, called at a negedge) and
    // check every completion until all of them are served.
    task automatic run_round(input logic [N_CH-1:0] mask);
        logic [N_CH-1:0]  pend;
        logic [IDX_W-1:0] idx;
        int exp_edge, s, c, guard;
        bit scr, got;
        pend = mask;
        for (int k = 0; k < N_CH; k++) if (mask[k]) drive_ch(k);
        exp_edge = cyc + LATENCY;
        while (pend != 0) begin
            got = 0;
            c   = 0;
            for (int i = 0; i < N_CH; i++) begin
                if (!got && pend[(rr_m + i) % N_CH]) begin
                    c   = (rr_m + i) % N_CH;
                    got = 1;
                end
            end
            s     = exp_edge - (LATENCY - 1);
            scr   = 0;
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
                if (!scr && cyc > s && bus.mem_ready == 0) begin
                    chk("busy_mid", busy, 1'b1);
                    bus.mem_addr[c*ADDR_W +: ADDR_W]  = ADDR_W'($urandom);
                    bus.mem_wdata[c*LINE_W +: LINE_W] = {$urandom, $urandom, $urandom, $urandom};
                    if ($urandom_range(0, 1) == 1) begin
                        bus.mem_read[c]  = 1'b0;
                        bus.mem_write[c] = 1'b0;
                    end
                    scr = 1;
                end
            end while (bus.mem_ready == 0 && guard < 4 * LATENCY);
            chk("ready_vec", bus.mem_ready, 256'(1) << c);
            chk("ready_time", cyc, exp_edge);
            chk("grant_ch", grant_ch, c);
            idx = addr_t[c][IDX_W-1:0];
            if (op_t[c] != 0) mem_m[idx] = data_t[c];
            if (op_t[c] == 2) proto_m = 1'b1;
            if (op_t[c] == 0) rd_m[c] = mem_m[idx];
            chk("rdata", bus.mem_rdata, rd_vec());
            bus.mem_read[c]  = 1'b0;
            bus.mem_write[c] = 1'b0;
            pend[c]  = 1'b0;
            rr_m     = (c + 1) % N_CH;
            if (xfer_m != 16'hFFFF) xfer_m = xfer_m + 16'd1;
            exp_edge = exp_edge + LATENCY + 1;
        end
        @(negedge clk);
        chk("busy_end", busy, 1'b0);
        chk("ready_end", bus.mem_ready, '0);
        chk("xfer_cnt", xfer_cnt, xfer_m);
        chk("proto_err", proto_err, proto_m);
    endtask

    task automatic one(input int c, input int op, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
        op_t[c]   = op;
        addr_t[c] = a;
        data_t[c] = d;
        run_round(N_CH'(1) << c);
    endtask

    task automatic rand_txn(input int c);
        op_t[c] = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
        addr_t[c] = ADDR_W'($urandom);
        addr_t[c][IDX_W-1:0] = IDX_W'($urandom_range(0, 15));
        data_t[c] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        logic [LINE_W-1:0] v;
        int s;
        rst           = 1'b1;
        bus.mem_read  = '0;
        bus.mem_write = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            v          = {$urandom, $urandom, $urandom, $urandom};
            dut.mem[i] = v;
            mem_m[i]   = v;
        end
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant_ch, '0);
        chk("rst_xfer", xfer_cnt, '0);
        chk("rst_proto", proto_err, 1'b0);
        chk("rst_ready", bus.mem_ready, '0);
        chk("rst_rdata", bus.mem_rdata, '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Write through an aliased address, read back via the base index
        one(1, 1, 28'h400, 128'h1234);
        one(1, 0, 28'h0, '0);
        chk("wr_rd_value", rd_m[1], 128'h1234);

        // Single read of a preloaded line
        dut.mem[5] = {16{8'hA5}};
        mem_m[5]   = {16{8'hA5}};
        one(0, 0, 28'd5, '0);

        // Contention: both channels requesting, alternating grants
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < N_CH; c++) begin
                op_t[c]   = 0;
                addr_t[c] = ADDR_W'($urandom_range(0, 31));
                data_t[c] = '0;
            end
            run_round(2'b11);
        end

        // Read and write together: performed as a write, sticky error
        one(0, 2, 28'd3, 128'hFF);
        chk("mem3", dut.mem[3], 128'hFF);
        one(1, 0, 28'd3, '0);

        // Reset during a write on channel 1
        op_t[1]   = 1;
        addr_t[1] = 28'd7;
        data_t[1] = 128'hDEAD_BEEF_0000_0000_CAFE_F00D_1111_2222;
        drive_ch(1);
        s = cyc + 1;
        while (cyc < s + 2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_grant", grant_ch, '0);
        chk("mid_rst_xfer", xfer_cnt, '0);
        chk("mid_rst_proto", proto_err, 1'b0);
        chk("mid_rst_rdata", bus.mem_rdata, '0);
        bus.mem_read  = '0;
        bus.mem_write = '0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_ready", bus.mem_ready, '0);
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("mem7_kept", dut.mem[7], mem_m[7]);
        one(0, 0, 28'd7, '0);

        // Transfer counter saturation
        force dut.xfer_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.xfer_cnt;
        xfer_m = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            rand_txn(i % N_CH);
            run_round(N_CH'(1) << (i % N_CH));
        end
        chk("xfer_sat", xfer_cnt, 16'hFFFF);

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            logic [N_CH-1:0] m;
            m = N_CH'($urandom_range(1, 3));
            for (int c = 0; c < N_CH; c++) if (m[c]) rand_txn(c);
            run_round(m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
